// File: rtl/map_ss_pkg.sv
// Shared types and sizing for the mapper save-state sequencer.
// The state enum and counter width are used by map_ss_engine.
package map_ss_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_TX   = 3'd3,
    L_RX   = 3'd4,
    L_ARM  = 3'd5,
    L_WE   = 3'd6,
    DONE   = 3'd7
  } state_t;

  localparam int SS_LEN_DEF = 256;
  localparam int CNT_W      = 9;

endpackage

// File: rtl/m2_edge_sync.sv
// Brings the asynchronous CPU m2 clock into the clk domain and
// produces one-cycle rise/fall pulses from the synchronized level.
module m2_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic m2,
  output logic m2_rise,
  output logic m2_fall
);

  logic sync1;
  logic sync2;
  logic prev;

  // two-flop synchronizer followed by a history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= m2;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign m2_rise = sync2 & ~prev;
  assign m2_fall = ~sync2 & prev;

endmodule

// File: rtl/map_ss_engine.sv
// Save-state sequencer: SAVE sweeps mapper registers out to tx stream,
// LOAD commits rx bytes through the mapper's negedge-m2 write path.
module map_ss_engine
  import map_ss_pkg::*;
#(
  parameter int SS_LEN = SS_LEN_DEF,
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m2,
  input  logic       cmd_save,
  input  logic       cmd_load,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic [7:0] tx_dat,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_dat,
  input  logic       rx_valid,
  output logic       rx_ready
);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       settle;
  logic             step;
  logic             last;
  logic             m2_rise;
  logic             m2_fall;

  m2_edge_sync u_m2_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .m2      (m2),
    .m2_rise (m2_rise),
    .m2_fall (m2_fall)
  );

  assign ss_addr = cnt[7:0];
  assign last    = (cnt == CNT_W'(SS_LEN - 1));

  // next-state selection; abort overrides everything
  always_comb begin
    state_n = state;
    step    = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_save)      state_n = S_ADDR;
          else if (cmd_load) state_n = L_RX;
          else               state_n = IDLE;
        end
        S_ADDR: state_n = S_WAIT;
        S_WAIT: begin
          if (settle <= 8'd1) state_n = S_TX;
          else                state_n = S_WAIT;
        end
        S_TX: begin
          if (tx_ready) begin
            step    = 1'b1;
            state_n = last ? DONE : S_ADDR;
          end else begin
            state_n = S_TX;
          end
        end
        L_RX: begin
          if (rx_valid) state_n = L_ARM;
          else          state_n = L_RX;
        end
        L_ARM: begin
          if (m2_rise) state_n = L_WE;
          else         state_n = L_ARM;
        end
        L_WE: begin
          if (m2_fall) begin
            step    = 1'b1;
            state_n = last ? DONE : L_RX;
          end else begin
            state_n = L_WE;
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // state, datapath and outputs, all registered off the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      settle   <= 8'd0;
      tx_dat   <= 8'd0;
      ss_wdat  <= 8'd0;
      tx_valid <= 1'b0;
      rx_ready <= 1'b0;
      ss_we    <= 1'b0;
      ss_act   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      tx_valid <= (state_n == S_TX);
      rx_ready <= (state_n == L_RX);
      ss_we    <= (state_n == L_WE);
      ss_act   <= (state_n != IDLE) && (state_n != DONE);
      busy     <= (state_n != IDLE);
      done     <= (state_n == DONE);
      if (state_n == IDLE) begin
        cnt     <= '0;
        settle  <= 8'd0;
        tx_dat  <= 8'd0;
        ss_wdat <= 8'd0;
      end else begin
        if (step) cnt <= cnt + CNT_W'(1);
        if (state == S_ADDR)      settle <= 8'(SETTLE);
        else if (state == S_WAIT) settle <= settle - 8'd1;
        // readback is captured once, on entry, so tx_dat holds through stalls
        if (state == S_WAIT && state_n == S_TX) tx_dat <= ss_rdat;
        if (state == L_RX && rx_valid) ss_wdat <= rx_dat;
      end
    end
  end

endmodule

// File: tb/tb_map_ss_engine.sv
// Randomized bench for map_ss_engine with a mapper register-file model,
// stream source/sink and an asynchronous m2 clock.
module tb_map_ss_engine;

  localparam int N = 256;

  logic       clk = 1'b0;
  logic       m2 = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_save, cmd_load, abort, tx_ready, rx_valid;
  logic [7:0] ss_rdat, rx_dat;
  logic       busy, done, ss_act, ss_we, tx_valid, rx_ready;
  logic [7:0] ss_addr, ss_wdat, tx_dat;

  bit         m2_run = 1'b1;
  logic [7:0] mapper_reg [N];
  int         wr_cnt [N];
  logic [7:0] rx_src [N];
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int         rx_idx, rx_len, tx_mode, cyc, done_cnt, wr_tot, viol, rx_seen;
  bit         last_done, pend_s, pend_l, pend_a;
  logic       prev_v, prev_r, m2_prev;
  logic [7:0] prev_d;
  int         n_tests, n_fail;

  assign ss_rdat = mapper_reg[ss_addr];

  map_ss_engine #(.SS_LEN(N), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .m2(m2), .cmd_save(cmd_save), .cmd_load(cmd_load),
    .abort(abort), .busy(busy), .done(done), .ss_act(ss_act), .ss_we(ss_we),
    .ss_addr(ss_addr), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat), .tx_dat(tx_dat),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_dat(rx_dat), .rx_valid(rx_valid),
    .rx_ready(rx_ready)
  );

  always #10 clk = ~clk;                       // 50 MHz
  always begin #279; m2 = m2_run ? ~m2 : 1'b0; end  // ~1.79 MHz, unrelated phase

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {2'b00, busy, done, ss_act, ss_we, tx_valid, rx_ready, ss_addr, tx_dat, ss_wdat};
  endfunction

  // one clk cycle: observe at negedge (mapper, streams), drive just after posedge
  task automatic tick();
    @(negedge clk);
    last_done = done;
    if (done) done_cnt++;
    if (tx_valid && tx_ready) got_q.push_back(tx_dat);
    if (prev_v && !prev_r && (!tx_valid || tx_dat != prev_d)) viol++;
    prev_v = tx_valid; prev_r = tx_ready; prev_d = tx_dat;
    if (rx_ready) rx_seen++;
    if (rx_valid && rx_ready) rx_idx++;
    if (m2_prev && !m2 && ss_act && ss_we) begin
      mapper_reg[ss_addr] = ss_wdat;
      wr_cnt[ss_addr]++;
      wr_tot++;
    end
    m2_prev = m2;
    @(posedge clk); #1;
    cyc++;
    case (tx_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = (((cyc / 3) % 2) == 0);
      default: tx_ready = 1'($urandom_range(1));
    endcase
    rx_valid = (rx_idx < rx_len) && ($urandom_range(3) != 0);
    rx_dat   = (rx_idx < rx_len) ? rx_src[rx_idx] : 8'h00;
    cmd_save = pend_s; cmd_load = pend_l; abort = pend_a;
    pend_s = 1'b0; pend_l = 1'b0; pend_a = 1'b0;
  endtask

  task automatic start(input bit s, input bit l);
    pend_s = s; pend_l = l;
    tick();
    tick();
  endtask

  task automatic run_to_done(input string tag, input int budget, input int load_at, output int n);
    bit pulsed;
    pulsed = 1'b0;
    n = 0;
    last_done = 1'b0;
    while (!last_done && n < budget) begin
      if (load_at >= 0 && !pulsed && got_q.size() == load_at) begin
        pend_l = 1'b1;
        pulsed = 1'b1;
      end
      tick();
      n++;
    end
    check_eq({tag, "_done_seen"}, 32'(last_done), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    int err;
    err = 0;
    for (int i = 0; i < N; i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) err++;
    check_eq({tag, "_count"}, 32'(got_q.size()), 32'(N));
    check_eq({tag, "_bytes_bad"}, 32'(err), 32'd0);
  endtask

  task automatic snapshot_random();
    for (int i = 0; i < N; i++) mapper_reg[i] = 8'($urandom);
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(mapper_reg[i]);
    got_q.delete();
  endtask

  task automatic check_load(input string tag, input int wr_base);
    int bad_val, bad_cnt;
    bad_val = 0; bad_cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (mapper_reg[i] !== rx_src[i]) bad_val++;
      if (wr_cnt[i] != 1) bad_cnt++;
    end
    check_eq({tag, "_regs_bad"}, 32'(bad_val), 32'd0);
    check_eq({tag, "_we_per_negedge_bad"}, 32'(bad_cnt), 32'd0);
    check_eq({tag, "_writes"}, 32'(wr_tot - wr_base), 32'(N));
  endtask

  initial begin
    int n, base, d0;
    cmd_save = 1'b0; cmd_load = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    rx_valid = 1'b0; rx_dat = 8'h00;
    rx_idx = 0; rx_len = 0; tx_mode = 0; cyc = 0; done_cnt = 0; wr_tot = 0;
    viol = 0; rx_seen = 0; n_tests = 0; n_fail = 0;
    prev_v = 1'b0; prev_r = 1'b0; prev_d = 8'h00; m2_prev = 1'b0;
    for (int i = 0; i < N; i++) begin mapper_reg[i] = 8'h00; wr_cnt[i] = 0; rx_src[i] = 8'h00; end

    repeat (4) tick();
    check_eq("reset_outs_in_reset", outs(), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    check_eq("reset_outs", outs(), 32'd0);

    // SAVE with both commands together, ss_rdat = ~ss_addr, ready always high
    for (int i = 0; i < N; i++) mapper_reg[i] = 8'(~i);
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(8'(N - 1 - i));
    got_q.delete(); rx_seen = 0; d0 = done_cnt; tx_mode = 0;
    start(1'b1, 1'b1);
    tick();
    check_eq("t1_first_cycle", {29'd0, ss_act, busy, rx_ready}, {29'd0, 3'b110});
    run_to_done("t1", 2000, -1, n);
    check_eq("t1_latency", 32'(n + 1), 32'd1025);
    check_stream("t1_stream");
    check_eq("t1_rx_ready_seen", 32'(rx_seen), 32'd0);
    tick();
    check_eq("t1_after_done", {29'd0, busy, ss_act, done}, 32'd0);
    check_eq("t1_done_pulses", 32'(done_cnt - d0), 32'd1);

    // SAVE with ready toggling every 3 cycles, load command at byte 10
    snapshot_random();
    tx_mode = 1; viol = 0; rx_seen = 0; d0 = done_cnt;
    start(1'b1, 1'b0);
    run_to_done("t2", 5000, 10, n);
    check_stream("t2_stream");
    check_eq("t2_stall_unstable", 32'(viol), 32'd0);
    check_eq("t2_rx_ready_seen", 32'(rx_seen), 32'd0);
    check_eq("t2_done_pulses", 32'(done_cnt - d0), 32'd1);

    // SAVE with random ready
    snapshot_random();
    tx_mode = 2; viol = 0;
    start(1'b1, 1'b0);
    run_to_done("t3", 5000, -1, n);
    check_stream("t3_stream");
    check_eq("t3_stall_unstable", 32'(viol), 32'd0);

    // LOAD 00..FF
    tx_mode = 0;
    for (int i = 0; i < N; i++) begin rx_src[i] = 8'(i); wr_cnt[i] = 0; end
    rx_idx = 0; rx_len = N; base = wr_tot;
    start(1'b0, 1'b1);
    run_to_done("t4", 20000, -1, n);
    check_load("t4", base);
    check_eq("t4_rx_consumed", 32'(rx_idx), 32'(N));
    tick();
    check_eq("t4_idle", {30'd0, busy, ss_act}, 32'd0);

    // LOAD aborted after 5 bytes
    for (int i = 0; i < N; i++) rx_src[i] = 8'($urandom);
    rx_idx = 0; base = wr_tot; d0 = done_cnt; n = 0;
    start(1'b0, 1'b1);
    while ((wr_tot - base) < 5 && n < 2000) begin tick(); n++; end
    check_eq("t5_reached_byte5", 32'(wr_tot - base), 32'd5);
    pend_a = 1'b1;
    tick();
    tick();
    check_eq("t5_abort_outs", outs(), 32'd0);
    repeat (20) tick();
    check_eq("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("t5_idle_outs", outs(), 32'd0);
    rx_len = 0;

    // reset mid-SAVE, then a fresh SAVE from address 0
    snapshot_random();
    start(1'b1, 1'b0);
    repeat (200) tick();
    d0 = done_cnt;
    rst_n = 1'b0;
    #2;
    check_eq("t6_rst_outs", outs(), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check_eq("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("t6_idle_outs", outs(), 32'd0);
    snapshot_random();
    start(1'b1, 1'b0);
    tick();
    check_eq("t6_restart_addr", {23'd0, ss_act, ss_addr}, {23'd0, 1'b1, 8'h00});
    run_to_done("t6", 2000, -1, n);
    check_stream("t6_stream");

    // LOAD with m2 held low, then resumed
    m2_run = 1'b0;
    repeat (30) tick();
    for (int i = 0; i < N; i++) begin rx_src[i] = 8'($urandom); wr_cnt[i] = 0; end
    rx_idx = 0; rx_len = N; base = wr_tot;
    start(1'b0, 1'b1);
    repeat (300) tick();
    check_eq("t7_stalled", {28'd0, busy, ss_act, rx_ready, ss_we}, {28'd0, 4'b1100});
    check_eq("t7_one_byte_taken", 32'(rx_idx), 32'd1);
    check_eq("t7_no_writes", 32'(wr_tot - base), 32'd0);
    m2_run = 1'b1;
    run_to_done("t7", 20000, -1, n);
    check_load("t7", base);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
